// File: rtl/emergency_request_conditioner_pkg.sv
// Shared definitions for the emergency request conditioner: FSM encoding and
// default timing constants aligned with the traffic controller's emergency window.
package emergency_request_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE_L = 2'd1,
    ACTIVE_R = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // Length of the downstream controller's emergency window, in cycles.
  localparam int EMERGENCY_WINDOW    = 11;

  localparam int DEF_DEBOUNCE        = 4;
  localparam int DEF_HOLD_CYCLES     = EMERGENCY_WINDOW;
  localparam int DEF_MAX_CYCLES      = 120;
  localparam int DEF_COOLDOWN_CYCLES = 8;

endpackage

// File: rtl/emergency_request_conditioner_sync_debounce.sv
// Two-flop synchroniser followed by a consecutive-sample debouncer for one
// raw asynchronous sensor.
module emergency_request_conditioner_sync_debounce
  import emergency_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensor,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // NOTE: registers use <= so each flop samples pre-edge values; with = the
  // two synchroniser stages would collapse into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= sensor;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        // DEBOUNCE-th consecutive differing sample: accept the new level.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/emergency_request_conditioner.sv
// Conditions two raw emergency sensors into mutually exclusive, time-bounded
// Emergency_Left/Emergency_Right requests with fault lockout and cooldown.
module emergency_request_conditioner
  import emergency_request_conditioner_pkg::*;
#(
  parameter int DEBOUNCE        = DEF_DEBOUNCE,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int MAX_CYCLES      = DEF_MAX_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sensor_left,
  input  logic sensor_right,
  output logic Emergency_Left,
  output logic Emergency_Right,
  output logic busy,
  output logic fault_left,
  output logic fault_right
);

  localparam int HOLD_W = $clog2(MAX_CYCLES);
  localparam int CD_W   = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] MAX_LAST  = HOLD_W'(MAX_CYCLES - 1);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic              deb_l;
  logic              deb_r;
  logic              pend_l;
  logic              pend_r;
  logic              mask_l;
  logic              mask_r;
  logic              req_l;
  logic              req_r;
  logic              forced_exit;
  logic              force_l;
  logic              force_r;
  logic              enter_l;
  logic              enter_r;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CD_W-1:0]   cd_cnt;

  emergency_request_conditioner_sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_deb_left (
    .clk     (clk),
    .reset_n (reset_n),
    .sensor  (sensor_left),
    .level   (deb_l)
  );

  emergency_request_conditioner_sync_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_deb_right (
    .clk     (clk),
    .reset_n (reset_n),
    .sensor  (sensor_right),
    .level   (deb_r)
  );

  assign req_l = (deb_l | pend_l) & ~mask_l;
  assign req_r = (deb_r | pend_r) & ~mask_r;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    forced_exit = 1'b0;
    case (state)
      IDLE: begin
        if (req_l)      next_state = ACTIVE_L;
        else if (req_r) next_state = ACTIVE_R;
      end
      ACTIVE_L: begin
        if (hold_cnt == MAX_LAST) begin
          next_state  = COOLDOWN;
          forced_exit = 1'b1;
        end else if (hold_cnt >= HOLD_LAST && !deb_l) begin
          next_state = COOLDOWN;
        end
      end
      ACTIVE_R: begin
        if (hold_cnt == MAX_LAST) begin
          next_state  = COOLDOWN;
          forced_exit = 1'b1;
        end else if (hold_cnt >= HOLD_LAST && !deb_r) begin
          next_state = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (cd_cnt == CD_LAST) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign force_l = forced_exit && (state == ACTIVE_L);
  assign force_r = forced_exit && (state == ACTIVE_R);
  assign enter_l = (state == IDLE) && (next_state == ACTIVE_L);
  assign enter_r = (state == IDLE) && (next_state == ACTIVE_R);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt        <= '0;
      cd_cnt          <= '0;
      pend_l          <= 1'b0;
      pend_r          <= 1'b0;
      mask_l          <= 1'b0;
      mask_r          <= 1'b0;
      fault_left      <= 1'b0;
      fault_right     <= 1'b0;
      Emergency_Left  <= 1'b0;
      Emergency_Right <= 1'b0;
      busy            <= 1'b0;
    end else begin
      // ACTIVE is only entered from IDLE, where the counter sits at zero.
      if (state == ACTIVE_L || state == ACTIVE_R) begin
        if (hold_cnt != MAX_LAST) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end

      if (state == COOLDOWN) begin
        if (cd_cnt != CD_LAST) cd_cnt <= cd_cnt + 1'b1;
      end else begin
        cd_cnt <= '0;
      end

      // A request blocked by the other channel (or a lost tie) is remembered
      // until served or until its sensor releases.
      if (enter_l || !deb_l) begin
        pend_l <= 1'b0;
      end else if (state == ACTIVE_R || state == COOLDOWN) begin
        pend_l <= 1'b1;
      end

      if (enter_r || !deb_r) begin
        pend_r <= 1'b0;
      end else if (state == ACTIVE_L || state == COOLDOWN ||
                   (state == IDLE && req_l && req_r)) begin
        pend_r <= 1'b1;
      end

      // A timed-out channel stays masked until its sensor is seen released.
      if (force_l)     mask_l <= 1'b1;
      else if (!deb_l) mask_l <= 1'b0;
      if (force_r)     mask_r <= 1'b1;
      else if (!deb_r) mask_r <= 1'b0;

      if (force_l) fault_left  <= 1'b1;
      if (force_r) fault_right <= 1'b1;

      Emergency_Left  <= (next_state == ACTIVE_L);
      Emergency_Right <= (next_state == ACTIVE_R);
      busy            <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_emergency_request_conditioner.sv
// Directed bench: stimulus queues the expected output transitions with their
// cycle numbers, and a negedge monitor pops and compares each transition seen.
module tb_emergency_request_conditioner;

  logic clk = 1'b0;
  logic reset_n;
  logic sensor_left;
  logic sensor_right;
  logic Emergency_Left;
  logic Emergency_Right;
  logic busy;
  logic fault_left;
  logic fault_right;

  always #5 clk = ~clk;

  emergency_request_conditioner #(
    .DEBOUNCE        (4),
    .HOLD_CYCLES     (11),
    .MAX_CYCLES      (120),
    .COOLDOWN_CYCLES (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_left     (sensor_left),
    .sensor_right    (sensor_right),
    .Emergency_Left  (Emergency_Left),
    .Emergency_Right (Emergency_Right),
    .busy            (busy),
    .fault_left      (fault_left),
    .fault_right     (fault_right)
  );

  // Output vector layout: {Emergency_Left, Emergency_Right, busy, fault_left, fault_right}
  localparam logic [4:0] V_IDLE    = 5'b00000;
  localparam logic [4:0] V_L_ACT   = 5'b10100;
  localparam logic [4:0] V_R_ACT   = 5'b01100;
  localparam logic [4:0] V_CD      = 5'b00100;
  localparam logic [4:0] V_IDLE_F  = 5'b00001;
  localparam logic [4:0] V_R_ACT_F = 5'b01101;
  localparam logic [4:0] V_CD_F    = 5'b00101;
  localparam logic [4:0] V_L_ACT_F = 5'b10101;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
    string      tag;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_ev;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         base;
  bit         mon_en = 1'b0;
  logic [4:0] mon_vec;
  logic [4:0] prev_vec = 5'b00000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc=%0d)", name, got, want, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [4:0] v, input string tag);
    exp_q.push_back('{cyc: c, vec: v, tag: tag});
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every change of the output vector is one DUT event.
  always @(negedge clk) begin
    if (mon_en) begin
      mon_vec = {Emergency_Left, Emergency_Right, busy, fault_left, fault_right};
      check("mutex", 32'(Emergency_Left & Emergency_Right), 32'd0);
      if (mon_vec !== prev_vec) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got=%b want=none (cyc=%0d)", mon_vec, cyc);
        end else begin
          mon_ev = exp_q.pop_front();
          check({mon_ev.tag, "_cyc"}, 32'(cyc), 32'(mon_ev.cyc));
          check({mon_ev.tag, "_val"}, 32'(mon_vec), 32'(mon_ev.vec));
        end
        prev_vec = mon_vec;
      end
    end
  end

  initial begin
    reset_n      = 1'b1;
    sensor_left  = 1'b0;
    sensor_right = 1'b0;
    #2 reset_n = 1'b0;
    wait_neg(3);
    check("reset_outputs",
          32'({Emergency_Left, Emergency_Right, busy, fault_left, fault_right}), 32'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    wait_neg(2);

    // 1: three-sample glitch is one short of DEBOUNCE and must vanish.
    base = cyc;
    sensor_left = 1'b1;
    wait_neg(3);
    sensor_left = 1'b0;
    wait_neg(15);
    check("t1_glitch", 32'({Emergency_Left, busy}), 32'd0);

    // 2: shortest accepted pulse (4 samples): rise after edge 6, 11-cycle
    // minimum hold, 8-cycle cooldown.
    base = cyc;
    expect_ev(base + 7,  V_L_ACT, "t2_rise");
    expect_ev(base + 18, V_CD,    "t2_fall");
    expect_ev(base + 26, V_IDLE,  "t2_idle");
    sensor_left = 1'b1;
    wait_neg(4);
    sensor_left = 1'b0;
    wait_neg(18);
    check("t2_cooldown_busy", 32'({busy, Emergency_Left}), 32'b10);
    wait_neg(8);

    // 3: simultaneous rise; left wins, right served after left + cooldown.
    // Right is held longer so its request is still live when served.
    base = cyc;
    expect_ev(base + 7,  V_L_ACT, "t3_left_rise");
    expect_ev(base + 27, V_CD,    "t3_left_fall");
    expect_ev(base + 35, V_IDLE,  "t3_idle_gap");
    expect_ev(base + 36, V_R_ACT, "t3_right_rise");
    expect_ev(base + 47, V_CD,    "t3_right_fall");
    expect_ev(base + 55, V_IDLE,  "t3_idle");
    sensor_left  = 1'b1;
    sensor_right = 1'b1;
    wait_neg(20);
    sensor_left = 1'b0;
    wait_neg(20);
    sensor_right = 1'b0;
    wait_neg(20);

    // 6: long press extends the request past the minimum hold, no fault.
    base = cyc;
    expect_ev(base + 7,  V_L_ACT, "t6_rise");
    expect_ev(base + 53, V_CD,    "t6_fall");
    expect_ev(base + 61, V_IDLE,  "t6_idle");
    sensor_left = 1'b1;
    wait_neg(30);
    check("t6_extended", 32'(Emergency_Left), 32'd1);
    wait_neg(16);
    sensor_left = 1'b0;
    wait_neg(19);
    check("t6_no_fault", 32'(fault_left), 32'd0);

    // 4: stuck right sensor: 120-cycle cap, fault, masked until released.
    base = cyc;
    expect_ev(base + 7,   V_R_ACT,   "t4_rise");
    expect_ev(base + 127, V_CD_F,    "t4_timeout");
    expect_ev(base + 135, V_IDLE_F,  "t4_idle");
    expect_ev(base + 182, V_R_ACT_F, "t4_rearm_rise");
    expect_ev(base + 193, V_CD_F,    "t4_rearm_fall");
    expect_ev(base + 201, V_IDLE_F,  "t4_rearm_idle");
    sensor_right = 1'b1;
    wait_neg(150);
    check("t4_masked", 32'({Emergency_Right, busy, fault_right}), 32'b001);
    wait_neg(15);
    sensor_right = 1'b0;
    wait_neg(10);
    sensor_right = 1'b1;
    wait_neg(10);
    sensor_right = 1'b0;
    wait_neg(20);
    check("t4_fault_sticky", 32'(fault_right), 32'd1);

    // 5: reset during ACTIVE_L clears everything; fresh 6-edge latency after.
    base = cyc;
    expect_ev(base + 7, V_L_ACT_F, "t5_rise");
    sensor_left = 1'b1;
    wait_neg(10);
    expect_ev(base + 11, V_IDLE, "t5_reset");
    #1 reset_n = 1'b0;
    #1;
    check("t5_async_drop",
          32'({Emergency_Left, Emergency_Right, busy, fault_left, fault_right}), 32'd0);
    wait_neg(3);
    reset_n = 1'b1;
    base = cyc;
    expect_ev(base + 7,  V_L_ACT, "t5_redetect");
    expect_ev(base + 18, V_CD,    "t5_fall");
    expect_ev(base + 26, V_IDLE,  "t5_idle");
    wait_neg(6);
    check("t5_latency_pre", 32'(Emergency_Left), 32'd0);
    wait_neg(4);
    sensor_left = 1'b0;
    wait_neg(20);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
